// File: rtl/game_pkg.sv
// Shared game constants and types.
//   - Game-status codes, shared with the memory-mapped I/O block.
//   - Screen geometry.
//   - The pipe_gen state encoding.
package game_pkg;

    localparam logic [1:0] ST_TITLE = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StFreeze = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_gen_if.sv
// Bus between pipe_gen and the memory-mapped I/O block.
//   frame_tick   : one-cycle pulse per VGA frame
//   game_status  : 0 title, 1 ready, 2 playing, 3 game over (bit 2 unused)
//   oxbuf        : pipe left-edge x, two's complement
//   oybuf        : gap-top y, unsigned
//   pipe_refresh : one-cycle pulse on pipe wrap (score event)
//   pipe_active  : high while running or frozen
// Modports: master = pipe_gen side, slave = I/O block side.
interface pipe_gen_if;

    logic        frame_tick;
    logic [2:0]  game_status;
    logic [10:0] oxbuf;
    logic [10:0] oybuf;
    logic        pipe_refresh;
    logic        pipe_active;

    modport master (
        input  frame_tick,
        input  game_status,
        output oxbuf,
        output oybuf,
        output pipe_refresh,
        output pipe_active
    );

    modport slave (
        output frame_tick,
        output game_status,
        input  oxbuf,
        input  oybuf,
        input  pipe_refresh,
        input  pipe_active
    );

endinterface

// File: rtl/pipe_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, taps 16/14/13/11 (maximal length).
//   clock : system clock
//   reset : synchronous, active-high; loads the seed
//   lfsr  : current LFSR state
// A zero seed would lock the register at zero, so it is replaced by 1.
module pipe_lfsr #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] lfsr
);

    localparam logic [15:0] Seed = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= Seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/pipe_gen.sv
// Scrolling pipe obstacle generator.
//   clock : system clock
//   reset : synchronous, active-high
//   bus   : pipe_gen_if.master (frame_tick, game_status in;
//           oxbuf, oybuf, pipe_refresh, pipe_active out)
// The pipe moves left by SPEED on each frame_tick while playing. Once it is
// fully off-screen it respawns at SCREEN_W with a pseudo-random gap height
// and pipe_refresh pulses for one cycle.
module pipe_gen #(
    parameter int          SCREEN_W  = 640,
    parameter int          PIPE_W    = 60,
    parameter int          SPEED     = 2,
    parameter int          Y_MIN     = 60,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    pipe_gen_if.master  bus
);

    import game_pkg::*;

    localparam logic signed [11:0] NegPipeW = 12'(-PIPE_W);

    pipe_state_e state_q, state_d;
    logic [10:0] ox_q, ox_d;
    logic [10:0] oy_q, oy_d;
    logic        refresh_q, refresh_d;
    logic        active_q, active_d;
    logic [11:0] nx;
    logic [15:0] lfsr;
    logic [1:0]  gs;
    logic        unused_gs2;

    assign gs         = bus.game_status[1:0];
    assign unused_gs2 = bus.game_status[2];

    pipe_lfsr #(
        .LFSR_SEED(LFSR_SEED)
    ) u_lfsr (
        .clock(clock),
        .reset(reset),
        .lfsr (lfsr)
    );

    always_comb begin
        state_d   = state_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        refresh_d = 1'b0;
        // Sign-extend to 12 bits so the step below can't wrap.
        nx        = {ox_q[10], ox_q} - 12'(SPEED);

        case (gs)
            ST_TITLE, ST_READY: state_d = StIdle;
            ST_PLAY:            state_d = StRun;
            default:            state_d = StFreeze;
        endcase

        unique case (state_q)
            StIdle: ox_d = 11'(SCREEN_W);
            StRun: begin
                // Requiring gs == PLAY blocks a move on the cycle we leave RUN.
                if (bus.frame_tick && gs == ST_PLAY) begin
                    if ($signed(nx) <= NegPipeW) begin
                        ox_d      = 11'(SCREEN_W);
                        oy_d      = 11'(Y_MIN) + {3'b000, lfsr[7:0]};
                        refresh_d = 1'b1;
                    end else begin
                        ox_d = nx[10:0];
                    end
                end
            end
            default: ;
        endcase

        active_d = (state_d != StIdle);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            ox_q      <= 11'(SCREEN_W);
            oy_q      <= 11'(Y_MIN);
            refresh_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            refresh_q <= refresh_d;
            active_q  <= active_d;
        end
    end

    assign bus.oxbuf        = ox_q;
    assign bus.oybuf        = oy_q;
    assign bus.pipe_refresh = refresh_q;
    assign bus.pipe_active  = active_q;

endmodule

// File: tb/tb_pipe_gen.sv
// Directed self-checking bench for pipe_gen plus a zero-seed pipe_lfsr.
module tb_pipe_gen;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        r;
        logic        a;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] l0;
    logic [15:0] m_lfsr;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ex    = 640;
    int          ey    = 60;
    exp_t        sb[$];

    always #5 clock = ~clock;

    pipe_gen_if bus ();

    pipe_gen u_dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    pipe_lfsr #(
        .LFSR_SEED(16'h0000)
    ) u_lfsr0 (
        .clock(clock),
        .reset(reset),
        .lfsr (l0)
    );

    // Reference LFSR: x^16 + x^14 + x^13 + x^11 + 1, seeded with 16'hACE1.
    always @(posedge clock) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, " oxbuf"}, 16'(bus.oxbuf), 16'(e.x));
        chk({tag, " oybuf"}, 16'(bus.oybuf), 16'(e.y));
        chk({tag, " refresh"}, 16'(bus.pipe_refresh), 16'(e.r));
        chk({tag, " active"}, 16'(bus.pipe_active), 16'(e.a));
    endtask

    // One frame_tick followed by a quiet cycle. run=1 when the bench expects
    // the pipe to be scrolling.
    task automatic tick(input string tag, input bit run, input bit act);
        exp_t e;
        int   nx;
        bus.frame_tick = 1'b1;
        e.r = 1'b0;
        if (run) begin
            nx = ex - 2;
            if (nx <= -60) begin
                ex  = 640;
                ey  = 60 + int'(m_lfsr[7:0]);
                e.r = 1'b1;
            end else begin
                ex = nx;
            end
        end
        e.x = 11'(ex);
        e.y = 11'(ey);
        e.a = act;
        sb.push_back(e);
        step();
        bus.frame_tick = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            chk_all(tag, e);
        end
        step();
        chk({tag, " refresh low after"}, 16'(bus.pipe_refresh), 16'd0);
    endtask

    initial begin
        exp_t e;
        int   period;
        bit   zero_seen;

        bus.frame_tick  = 1'b0;
        bus.game_status = 3'd0;
        reset = 1'b1;
        repeat (3) step();
        e = '{x: 11'd640, y: 11'd60, r: 1'b0, a: 1'b0};
        chk_all("reset", e);
        reset = 1'b0;
        step();
        for (int i = 0; i < 10; i++) tick("idle", 1'b0, 1'b0);

        // Scrolling.
        bus.game_status = 3'd2;
        step();
        step();
        chk("run active", 16'(bus.pipe_active), 16'd1);
        chk("run no move", 16'(bus.oxbuf), 16'd640);
        tick("scroll first", 1'b1, 1'b1);
        chk("x 638", 16'(bus.oxbuf), 16'd638);
        for (int i = 1; i < 100; i++) tick("scroll", 1'b1, 1'b1);
        chk("x 440", 16'(bus.oxbuf), 16'd440);

        // Wrap: 349 ticks from 640 reach -58, the 350th wraps.
        for (int i = 100; i < 349; i++) tick("scroll", 1'b1, 1'b1);
        chk("x -58", 16'(bus.oxbuf), 16'h07C6);
        tick("wrap", 1'b1, 1'b1);
        chk("x after wrap", 16'(bus.oxbuf), 16'd640);

        // Freeze at 300.
        for (int i = 0; i < 170; i++) tick("scroll2", 1'b1, 1'b1);
        chk("x 300", 16'(bus.oxbuf), 16'd300);
        bus.game_status = 3'd3;
        step();
        for (int i = 0; i < 20; i++) tick("freeze", 1'b0, 1'b1);
        chk("freeze x", 16'(bus.oxbuf), 16'd300);
        bus.game_status = 3'd0;
        repeat (3) step();
        ex = 640;
        e = '{x: 11'd640, y: 11'(ey), r: 1'b0, a: 1'b0};
        chk_all("back to idle", e);

        // Tick on the same cycle status leaves PLAY.
        bus.game_status = 3'd2;
        step();
        step();
        tick("pre", 1'b1, 1'b1);
        tick("pre", 1'b1, 1'b1);
        bus.frame_tick  = 1'b1;
        bus.game_status = 3'd3;
        step();
        bus.frame_tick = 1'b0;
        e = '{x: 11'd636, y: 11'(ey), r: 1'b0, a: 1'b1};
        chk_all("tick on exit", e);
        step();
        chk("tick on exit later", 16'(bus.oxbuf), 16'd636);

        // Reset on a wrap tick.
        bus.game_status = 3'd2;
        step();
        step();
        for (int i = 0; i < 347; i++) tick("scroll3", 1'b1, 1'b1);
        chk("x -58 again", 16'(bus.oxbuf), 16'h07C6);
        bus.frame_tick = 1'b1;
        reset = 1'b1;
        step();
        bus.frame_tick  = 1'b0;
        bus.game_status = 3'd0;
        ex = 640;
        ey = 60;
        e = '{x: 11'd640, y: 11'd60, r: 1'b0, a: 1'b0};
        chk_all("reset on wrap", e);
        step();
        chk("reset on wrap later", 16'(bus.pipe_refresh), 16'd0);

        // Zero-seed LFSR: substituted seed, never zero, full period.
        chk("lfsr0 seed", l0, 16'h0001);
        reset = 1'b0;
        period    = 0;
        zero_seen = 1'b0;
        for (int i = 1; i <= 70000; i++) begin
            step();
            if (l0 == 16'h0000) zero_seen = 1'b1;
            if (period == 0 && l0 == 16'h0001) period = i;
        end
        chk("lfsr0 zero seen", 16'(zero_seen), 16'd0);
        chk("lfsr0 period", 16'(period), 16'd65535);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
